// File: rtl/spi_master_arbiter.sv
// spi_master_arbiter: shares one SPCR/SPSR/SPDR SPI master between two requesters.
// Optional `SPI_MASTER_ARBITER_ROUND_ROBIN_EN selects round-robin tie-break (default fixed priority).
module spi_master_arbiter #(
  parameter int                           BUS_ADDR_DATA_LEN = 8,
  parameter logic [BUS_ADDR_DATA_LEN-1:0] SPCR_ADDR         = 'h20,
  parameter logic [BUS_ADDR_DATA_LEN-1:0] SPSR_ADDR         = 'h21,
  parameter logic [BUS_ADDR_DATA_LEN-1:0] SPDR_ADDR         = 'h22,
  parameter logic [7:0]                   SPCR0_VAL         = 8'h50,
  parameter logic [7:0]                   SPCR1_VAL         = 8'h50,
  parameter int                           CS_SETUP_CYC      = 2,
  parameter int                           CS_HOLD_CYC       = 2,
  parameter int                           POLL_TIMEOUT      = 1023
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [1:0]                   req,
  output logic [1:0]                   gnt,
  input  logic [1:0]                   tx_valid,
  input  logic [15:0]                  tx_data,
  output logic [1:0]                   tx_ready,
  output logic [1:0]                   rx_valid,
  output logic [7:0]                   rx_data,
  output logic [1:0]                   err,
  output logic [1:0]                   cs_n,
  output logic [BUS_ADDR_DATA_LEN-1:0] spi_addr,
  output logic                         spi_wr,
  output logic                         spi_rd,
  output logic [7:0]                   spi_dat_out,
  input  logic [7:0]                   spi_dat_in
);

  typedef enum logic [3:0] {
    IDLE, CFG, SETUP, WAITTX, WRDR, POLL, RDDR, HOLD, RELEASE
  } state_t;

  state_t     state, state_nx;
  logic       own;
  logic       pick;
  logic [1:0] own_oh;
  logic [3:0] dly_cnt;
  logic [9:0] poll_cnt;
  logic       setup_done;
  logic       hold_done;
  logic       poll_last;
  logic       spif;

`ifdef SPI_MASTER_ARBITER_ROUND_ROBIN_EN
  logic rr;

  // Round-robin pointer flips away from the requester just served.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                   rr <= 1'b0;
    else if (state == RELEASE) rr <= ~own;
  end

  assign pick = (req == 2'b11) ? rr : ~req[0];
`else
  assign pick = ~req[0];
`endif

  assign own_oh     = own ? 2'b10 : 2'b01;
  assign spif       = spi_dat_in[7];
  assign setup_done = ({1'b0, dly_cnt} + 5'd1) >= 5'(CS_SETUP_CYC);
  assign hold_done  = ({1'b0, dly_cnt} + 5'd1) >= 5'(CS_HOLD_CYC);
  assign poll_last  = poll_cnt == 10'(POLL_TIMEOUT - 1);

  // State register and latched owner for the whole transaction.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      own   <= 1'b0;
    end else begin
      state <= state_nx;
      if (state == IDLE && |req) own <= pick;
    end
  end

  // Cycle counters for cs setup/hold and SPSR polling.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dly_cnt  <= '0;
      poll_cnt <= '0;
    end else begin
      if (state == SETUP || state == HOLD) dly_cnt <= dly_cnt + 4'd1;
      else                                 dly_cnt <= '0;
      if (state == WRDR)               poll_cnt <= '0;
      else if (state == POLL && !spif) poll_cnt <= poll_cnt + 10'd1;
    end
  end

  // Received byte capture; rx_valid follows the SPDR read by one cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_data  <= '0;
      rx_valid <= '0;
    end else begin
      rx_valid <= (state == RDDR) ? own_oh : 2'b00;
      if (state == RDDR) rx_data <= spi_dat_in;
    end
  end

  // Next-state and register-bus/handshake outputs.
  always_comb begin
    state_nx    = state;
    gnt         = 2'b00;
    cs_n        = 2'b11;
    tx_ready    = 2'b00;
    err         = 2'b00;
    spi_wr      = 1'b0;
    spi_rd      = 1'b0;
    spi_addr    = '0;
    spi_dat_out = '0;
    unique case (state)
      IDLE: begin
        if (|req) state_nx = CFG;
      end
      CFG: begin
        gnt         = own_oh;
        spi_wr      = 1'b1;
        spi_addr    = SPCR_ADDR;
        spi_dat_out = (own ? SPCR1_VAL : SPCR0_VAL) | 8'h50;
        state_nx    = SETUP;
      end
      SETUP: begin
        gnt  = own_oh;
        cs_n = ~own_oh;
        if (setup_done) state_nx = WAITTX;
      end
      WAITTX: begin
        gnt  = own_oh;
        cs_n = ~own_oh;
        if (!req[own])          state_nx = HOLD;
        else if (tx_valid[own]) state_nx = WRDR;
      end
      WRDR: begin
        gnt         = own_oh;
        cs_n        = ~own_oh;
        spi_wr      = 1'b1;
        spi_addr    = SPDR_ADDR;
        spi_dat_out = own ? tx_data[15:8] : tx_data[7:0];
        tx_ready    = own_oh;
        state_nx    = POLL;
      end
      POLL: begin
        gnt      = own_oh;
        cs_n     = ~own_oh;
        spi_rd   = 1'b1;
        spi_addr = SPSR_ADDR;
        if (spif) begin
          state_nx = RDDR;
        end else if (poll_last) begin
          err      = own_oh;
          state_nx = HOLD;
        end
      end
      RDDR: begin
        gnt      = own_oh;
        cs_n     = ~own_oh;
        spi_rd   = 1'b1;
        spi_addr = SPDR_ADDR;
        state_nx = WAITTX;
      end
      HOLD: begin
        gnt  = own_oh;
        cs_n = ~own_oh;
        if (hold_done) state_nx = RELEASE;
      end
      RELEASE: begin
        state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

endmodule

// File: tb/tb_spi_master_arbiter.sv
// tb_spi_master_arbiter: directed checks against a small loopback SPI peripheral model.
// Requester 0 uses SPCR0_VAL=8'h51 and POLL_TIMEOUT=15.
module tb_spi_master_arbiter;

  localparam int SETUP_C = 2;
  localparam int HOLD_C  = 2;
  localparam int TMO     = 15;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  req, gnt, tx_valid, tx_ready, rx_valid, err, cs_n;
  logic [15:0] tx_data;
  logic [7:0]  rx_data, spi_addr, spi_dat_out, spi_dat_in;
  logic        spi_wr, spi_rd;

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;

  spi_master_arbiter #(
    .SPCR0_VAL(8'h51), .CS_SETUP_CYC(SETUP_C),
    .CS_HOLD_CYC(HOLD_C), .POLL_TIMEOUT(TMO)
  ) dut (
    .clk(clk), .rst(rst), .req(req), .gnt(gnt),
    .tx_valid(tx_valid), .tx_data(tx_data), .tx_ready(tx_ready),
    .rx_valid(rx_valid), .rx_data(rx_data), .err(err), .cs_n(cs_n),
    .spi_addr(spi_addr), .spi_wr(spi_wr), .spi_rd(spi_rd),
    .spi_dat_out(spi_dat_out), .spi_dat_in(spi_dat_in)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  // Peripheral model: loopback, SPIF three cycles after an SPDR write.
  logic       spif, stub;
  logic [7:0] shreg, rxreg;
  logic [2:0] busy;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      spif <= 0; busy <= 0; shreg <= 0; rxreg <= 0;
    end else begin
      if (spi_wr && spi_addr == 8'h22) begin
        shreg <= spi_dat_out;
        busy  <= 3'd3;
      end else if (busy != 0) begin
        busy <= busy - 3'd1;
        if (busy == 3'd1 && !stub) begin
          spif  <= 1'b1;
          rxreg <= shreg;
        end
      end
      if (spi_rd && spi_addr == 8'h21 && spif) spif <= 1'b0;
    end
  end

  assign spi_dat_in = (spi_addr == 8'h21) ? {spif, 7'b0} :
                      (spi_addr == 8'h22) ? rxreg : 8'h00;

  // Event log and always-on invariants.
  int n_wr, wr_cyc, spcr_cyc, cs_fall_cyc, cs_rise_cyc;
  int n_rx, n_rx1, last_rx_cyc, n_err, err_cyc, n_polls, polls_at_err;
  int n_txr1, gnt1_seen, n_grant;
  int grant_log [4];
  logic [7:0] spcr_val;
  logic [7:0] rx_log [8];
  int g_tx, g_rx, g_err;
  logic [1:0] prev_gnt, prev_cs;

  task automatic clear_log();
    n_wr = 0; wr_cyc = 0; spcr_cyc = 0; cs_fall_cyc = 0; cs_rise_cyc = 0;
    n_rx = 0; n_rx1 = 0; last_rx_cyc = 0; n_err = 0; err_cyc = 0;
    n_polls = 0; polls_at_err = 0; n_txr1 = 0; gnt1_seen = 0; n_grant = 0;
    spcr_val = 8'h00;
    for (int i = 0; i < 4; i++) grant_log[i] = -1;
    for (int i = 0; i < 8; i++) rx_log[i] = 8'h00;
  endtask

  always @(negedge clk) begin
    if (rst) begin
      g_tx = 0; g_rx = 0; g_err = 0; prev_gnt = 2'b00; prev_cs = 2'b11;
    end else begin
      vectors++;
      if (cs_n == 2'b00) begin
        miscompares++;
        $display("FAIL cs_onehot cyc=%0d cs_n=%b required not 00", cyc, cs_n);
      end
      vectors++;
      if (spi_wr && spi_rd) begin
        miscompares++;
        $display("FAIL wr_rd_excl cyc=%0d wr=1 rd=1 required not both", cyc);
      end
      if (spi_wr && spi_addr == 8'h20) begin spcr_val = spi_dat_out; spcr_cyc = cyc; end
      if (spi_wr && spi_addr == 8'h22) begin
        if (n_wr == 0) wr_cyc = cyc;
        n_wr++;
      end
      if (spi_rd && spi_addr == 8'h21) n_polls++;
      if (!cs_n[0] && prev_cs[0]) cs_fall_cyc = cyc;
      if (cs_n[0] && !prev_cs[0]) cs_rise_cyc = cyc;
      if (rx_valid[0]) begin
        if (n_rx < 8) rx_log[n_rx] = rx_data;
        n_rx++; last_rx_cyc = cyc;
      end
      if (rx_valid[1]) n_rx1++;
      if (err[0]) begin n_err++; err_cyc = cyc; polls_at_err = n_polls; end
      if (tx_ready[1]) n_txr1++;
      if (gnt[1]) gnt1_seen = 1;
      if (gnt != 0 && prev_gnt == 0) begin
        if (n_grant < 4) grant_log[n_grant] = gnt[1] ? 1 : 0;
        n_grant++;
      end
      g_tx  += $countones(tx_ready);
      g_rx  += $countones(rx_valid);
      g_err += $countones(err);
      if (prev_gnt != 0 && gnt == 0) begin
        vectors++;
        if (g_tx != g_rx + g_err) begin
          miscompares++;
          $display("FAIL grant_balance cyc=%0d tx_ready=%0d required rx+err=%0d",
                   cyc, g_tx, g_rx + g_err);
        end
        g_tx = 0; g_rx = 0; g_err = 0;
      end
      prev_gnt = gnt;
      prev_cs  = cs_n;
    end
  end

  task automatic test_reset();
    rst = 1; req = 0; tx_valid = 0; tx_data = 0; stub = 0;
    clear_log();
    #1;
    vectors++;
    if ({gnt, tx_ready, rx_valid, err, spi_wr, spi_rd} !== 10'b0) begin
      miscompares++;
      $display("FAIL reset_ctl got=%b required 0",
               {gnt, tx_ready, rx_valid, err, spi_wr, spi_rd});
    end
    vectors++;
    if (cs_n !== 2'b11) begin
      miscompares++; $display("FAIL reset_cs got=%b required 11", cs_n);
    end
    vectors++;
    if ({rx_data, spi_addr, spi_dat_out} !== 24'h0) begin
      miscompares++;
      $display("FAIL reset_bus got=%h required 0", {rx_data, spi_addr, spi_dat_out});
    end
    repeat (3) @(posedge clk);
    #1 rst = 0;
    repeat (2) @(negedge clk);
    vectors++;
    if (gnt !== 2'b00 || cs_n !== 2'b11) begin
      miscompares++; $display("FAIL idle_after_reset gnt=%b cs_n=%b required 00/11", gnt, cs_n);
    end
  endtask

  task automatic test_two_bytes();
    bit ok;
    clear_log();
    @(posedge clk); #1;
    req = 2'b01; tx_valid = 2'b01; tx_data = 16'h00A5;
    ok = 0;
    for (int i = 0; i < 50; i++) begin @(negedge clk); if (tx_ready[0]) begin ok = 1; break; end end
    vectors++;
    if (!ok) begin miscompares++; $display("FAIL tb_txr_a got=timeout required tx_ready"); end
    @(posedge clk); #1 tx_data = 16'h003C;
    ok = 0;
    for (int i = 0; i < 50; i++) begin @(negedge clk); if (tx_ready[0]) begin ok = 1; break; end end
    vectors++;
    if (!ok) begin miscompares++; $display("FAIL tb_txr_b got=timeout required tx_ready"); end
    @(posedge clk); #1 req = 0; tx_valid = 0;
    ok = 0;
    for (int i = 0; i < 50; i++) begin @(negedge clk); if (cs_n[0]) begin ok = 1; break; end end
    vectors++;
    if (!ok) begin miscompares++; $display("FAIL tb_cs_rise got=timeout required cs_n[0]=1"); end
    repeat (2) @(negedge clk);
    vectors++;
    if (spcr_val !== 8'h51 || spcr_cyc >= cs_fall_cyc) begin
      miscompares++;
      $display("FAIL spcr_first val=%h at %0d required 51 before cs fall %0d",
               spcr_val, spcr_cyc, cs_fall_cyc);
    end
    vectors++;
    if (wr_cyc - cs_fall_cyc != SETUP_C + 1) begin
      miscompares++;
      $display("FAIL setup_gap got=%0d required %0d", wr_cyc - cs_fall_cyc, SETUP_C + 1);
    end
    vectors++;
    if (n_rx != 2 || n_wr != 2) begin
      miscompares++; $display("FAIL rx_count got rx=%0d wr=%0d required 2/2", n_rx, n_wr);
    end
    vectors++;
    if (rx_log[0] !== 8'hA5 || rx_log[1] !== 8'h3C) begin
      miscompares++;
      $display("FAIL rx_bytes got=%h,%h required a5,3c", rx_log[0], rx_log[1]);
    end
    vectors++;
    if (cs_rise_cyc - last_rx_cyc != HOLD_C + 1) begin
      miscompares++;
      $display("FAIL hold_gap got=%0d required %0d", cs_rise_cyc - last_rx_cyc, HOLD_C + 1);
    end
  endtask

  task automatic test_tie();
    bit ok;
    clear_log();
    @(posedge clk); #1;
    req = 2'b11; tx_valid = 2'b11; tx_data = 16'h2211;
`ifdef SPI_MASTER_ARBITER_ROUND_ROBIN_EN
    ok = 0;
    for (int i = 0; i < 50; i++) begin @(negedge clk); if (tx_ready[0]) begin ok = 1; break; end end
    @(posedge clk); #1 req[0] = 0; tx_valid[0] = 0;
    for (int i = 0; i < 100 && ok; i++) begin
      @(negedge clk); if (tx_ready[1]) break;
      if (i == 99) ok = 0;
    end
    @(posedge clk); #1 req = 0; tx_valid = 0;
    vectors++;
    if (!ok) begin miscompares++; $display("FAIL rr_tx got=timeout required both tx_ready"); end
    repeat (20) @(negedge clk);
    vectors++;
    if (n_grant != 2 || grant_log[0] != 0 || grant_log[1] != 1) begin
      miscompares++;
      $display("FAIL rr_order got n=%0d %0d,%0d required 2 0,1", n_grant, grant_log[0], grant_log[1]);
    end
    vectors++;
    if (n_rx != 1 || n_rx1 != 1) begin
      miscompares++; $display("FAIL rr_rx got=%0d/%0d required 1/1", n_rx, n_rx1);
    end
`else
    repeat (60) @(negedge clk);
    @(posedge clk); #1 req = 0; tx_valid = 0;
    ok = 0;
    for (int i = 0; i < 50; i++) begin @(negedge clk); if (cs_n[0]) begin ok = 1; break; end end
    vectors++;
    if (!ok) begin miscompares++; $display("FAIL tie_release got=timeout required cs_n[0]=1"); end
    repeat (4) @(negedge clk);
    vectors++;
    if (gnt1_seen != 0 || n_txr1 != 0) begin
      miscompares++;
      $display("FAIL fixed_prio gnt1=%0d txr1=%0d required 0/0", gnt1_seen, n_txr1);
    end
    vectors++;
    if (n_rx < 2 || rx_log[0] !== 8'h11) begin
      miscompares++; $display("FAIL fixed_rx got n=%0d b=%h required >=2 11", n_rx, rx_log[0]);
    end
`endif
  endtask

  task automatic test_timeout();
    bit ok;
    clear_log();
    stub = 1;
    @(posedge clk); #1;
    req = 2'b01; tx_valid = 2'b01; tx_data = 16'h005A;
    ok = 0;
    for (int i = 0; i < 100; i++) begin @(negedge clk); if (err[0]) begin ok = 1; break; end end
    vectors++;
    if (!ok) begin miscompares++; $display("FAIL tmo_err got=timeout required err[0]"); end
    @(posedge clk); #1 req = 0; tx_valid = 0;
    ok = 0;
    for (int i = 0; i < 50; i++) begin @(negedge clk); if (cs_n[0]) begin ok = 1; break; end end
    vectors++;
    if (!ok || gnt !== 2'b00) begin
      miscompares++; $display("FAIL tmo_release cs_n=%b gnt=%b required 11/00", cs_n, gnt);
    end
    repeat (3) @(negedge clk);
    stub = 0;
    vectors++;
    if (polls_at_err != TMO || n_err != 1) begin
      miscompares++;
      $display("FAIL tmo_polls got=%0d err=%0d required %0d/1", polls_at_err, n_err, TMO);
    end
    vectors++;
    if (n_rx != 0 || cs_rise_cyc - err_cyc != HOLD_C + 1) begin
      miscompares++;
      $display("FAIL tmo_after rx=%0d gap=%0d required 0/%0d", n_rx, cs_rise_cyc - err_cyc, HOLD_C + 1);
    end
  endtask

  task automatic test_drop_in_poll();
    bit ok;
    clear_log();
    @(posedge clk); #1;
    req = 2'b01; tx_valid = 2'b01; tx_data = 16'h00C3;
    ok = 0;
    for (int i = 0; i < 50; i++) begin @(negedge clk); if (tx_ready[0]) begin ok = 1; break; end end
    @(posedge clk); #1;
    vectors++;
    if (!ok || spi_rd !== 1'b1) begin
      miscompares++; $display("FAIL drop_in_poll spi_rd=%b required 1", spi_rd);
    end
    req = 2'b00;
    ok = 0;
    for (int i = 0; i < 50; i++) begin @(negedge clk); if (cs_n[0]) begin ok = 1; break; end end
    vectors++;
    if (!ok) begin miscompares++; $display("FAIL drop_release got=timeout required cs_n[0]=1"); end
    repeat (3) @(negedge clk);
    tx_valid = 0;
    vectors++;
    if (n_rx != 1 || rx_log[0] !== 8'hC3 || n_wr != 1) begin
      miscompares++;
      $display("FAIL drop_byte rx=%0d b=%h wr=%0d required 1 c3 1", n_rx, rx_log[0], n_wr);
    end
  endtask

  task automatic test_reset_in_poll();
    bit ok;
    clear_log();
    @(posedge clk); #1;
    req = 2'b01; tx_valid = 2'b01; tx_data = 16'h0099;
    ok = 0;
    for (int i = 0; i < 50; i++) begin @(negedge clk); if (tx_ready[0]) begin ok = 1; break; end end
    @(posedge clk); #1 rst = 1;
    #1;
    vectors++;
    if (!ok || cs_n !== 2'b11 || gnt !== 2'b00 || spi_rd !== 1'b0) begin
      miscompares++;
      $display("FAIL rst_in_poll cs_n=%b gnt=%b rd=%b required 11/00/0", cs_n, gnt, spi_rd);
    end
    req = 0; tx_valid = 0;
    repeat (2) @(posedge clk);
    #1 rst = 0;
    clear_log();
    @(posedge clk); #1;
    req = 2'b01; tx_valid = 2'b01; tx_data = 16'h0077;
    ok = 0;
    for (int i = 0; i < 50; i++) begin @(negedge clk); if (tx_ready[0]) begin ok = 1; break; end end
    @(posedge clk); #1 req = 0; tx_valid = 0;
    for (int i = 0; i < 50 && ok; i++) begin
      @(negedge clk); if (cs_n[0]) break;
      if (i == 49) ok = 0;
    end
    repeat (2) @(negedge clk);
    vectors++;
    if (!ok || n_rx != 1 || rx_log[0] !== 8'h77 || spcr_val !== 8'h51) begin
      miscompares++;
      $display("FAIL post_rst_txn rx=%0d b=%h spcr=%h required 1 77 51", n_rx, rx_log[0], spcr_val);
    end
  endtask

  initial begin
    test_reset();
    test_two_bytes();
    test_tie();
    test_timeout();
    test_drop_in_poll();
    test_reset_in_poll();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=no finish required finish");
    $fatal(1, "watchdog");
  end

endmodule
